// File: rtl/tdc_measure_ctrl_pkg.sv
// Shared constants for the TDC measurement controller: FSM state encodings and the
// default coarse-counter width, also used by downstream result assembly.
package tdc_measure_ctrl_pkg;

  localparam int COARSE_W_DEFAULT = 16;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_WAIT_START = 3'd1;
  localparam logic [2:0] ST_WAIT_CLEAR = 3'd2;
  localparam logic [2:0] ST_WAIT_STOP  = 3'd3;
  localparam logic [2:0] ST_DONE       = 3'd4;

endpackage

// File: rtl/tdc_measure_ctrl_if.sv
// Control/result bundle between the measurement controller (slave) and its
// requester plus the Fine delay line (master side).
interface tdc_measure_ctrl_if #(
  parameter int COARSE_W = tdc_measure_ctrl_pkg::COARSE_W_DEFAULT
) ();

  logic                iArm;
  logic                iAbort;
  logic                iTap0;
  logic                iReady;
  logic                oStartEnable;
  logic                oStopEnable;
  logic                oValid;
  logic [COARSE_W-1:0] oCoarse;
  logic                oTimeout;
  logic                oBusy;

  modport master (
    output iArm, iAbort, iTap0, iReady,
    input  oStartEnable, oStopEnable, oValid, oCoarse, oTimeout, oBusy
  );

  modport slave (
    input  iArm, iAbort, iTap0, iReady,
    output oStartEnable, oStopEnable, oValid, oCoarse, oTimeout, oBusy
  );

endinterface

// File: rtl/tdc_coarse_counter.sv
// Coarse period counter: synchronous clear, count enable, saturates at all-ones
// and flags saturation so the controller can declare a timeout.
module tdc_coarse_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         sat
);

  logic [W-1:0] count_q, count_d;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !sat) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign sat   = &count_q;

endmodule

// File: rtl/tdc_measure_ctrl.sv
// Sequences one start/stop capture on the Fine delay line, counts whole clock periods
// between the two captures and presents the result with a valid/ready handshake.
module tdc_measure_ctrl
  import tdc_measure_ctrl_pkg::*;
#(
  parameter int COARSE_W = COARSE_W_DEFAULT
) (
  input logic               clk,
  input logic               iRst,
  tdc_measure_ctrl_if.slave bus
);

  logic [2:0]          state_q, state_d;
  logic [COARSE_W-1:0] coarse_q, coarse_d;
  logic                timeout_q, timeout_d;
  logic                start_en_q, start_en_d;
  logic                stop_en_q, stop_en_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  logic                cnt_clr, cnt_en, cnt_sat;
  logic [COARSE_W-1:0] cnt;

  tdc_coarse_counter #(.W(COARSE_W)) u_coarse_counter (
    .clk   (clk),
    .rst   (iRst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt),
    .sat   (cnt_sat)
  );

  always_comb begin
    state_d   = state_q;
    coarse_d  = coarse_q;
    timeout_d = timeout_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;

    if (bus.iAbort) begin
      state_d   = ST_IDLE;
      coarse_d  = '0;
      timeout_d = 1'b0;
      cnt_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.iArm) state_d = ST_WAIT_START;
        end
        ST_WAIT_START: begin
          // The Start column latches this same tap sample, so the count starts here.
          if (bus.iTap0) begin
            state_d = ST_WAIT_CLEAR;
            cnt_clr = 1'b1;
          end
        end
        ST_WAIT_CLEAR: begin
          if (cnt_sat) begin
            state_d   = ST_DONE;
            coarse_d  = '1;
            timeout_d = 1'b1;
          end else begin
            cnt_en = 1'b1;
            if (!bus.iTap0) state_d = ST_WAIT_STOP;
          end
        end
        ST_WAIT_STOP: begin
          // A saturated counter means the gap already exceeds CMAX; report timeout.
          if (cnt_sat) begin
            state_d   = ST_DONE;
            coarse_d  = '1;
            timeout_d = 1'b1;
          end else if (bus.iTap0) begin
            state_d   = ST_DONE;
            coarse_d  = cnt + 1'b1;
            timeout_d = 1'b0;
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.iReady) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so no input reaches an output combinationally.
  always_comb begin
    start_en_d = (state_d == ST_WAIT_START);
    stop_en_d  = (state_d == ST_WAIT_STOP);
    valid_d    = (state_d == ST_DONE);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (iRst) begin
      state_q    <= ST_IDLE;
      coarse_q   <= '0;
      timeout_q  <= 1'b0;
      start_en_q <= 1'b0;
      stop_en_q  <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      coarse_q   <= coarse_d;
      timeout_q  <= timeout_d;
      start_en_q <= start_en_d;
      stop_en_q  <= stop_en_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.oStartEnable = start_en_q;
  assign bus.oStopEnable  = stop_en_q;
  assign bus.oValid       = valid_q;
  assign bus.oCoarse      = coarse_q;
  assign bus.oTimeout     = timeout_q;
  assign bus.oBusy        = busy_q;

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// Self-checking bench: a 16-bit controller for normal/abort/backpressure/reset cases and
// a 4-bit controller for saturation; expectations come from capture-edge arithmetic.
module tb_tdc_measure_ctrl;

  localparam int CMAX_S = (1 << 4) - 1;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  tdc_measure_ctrl_if #(.COARSE_W(16)) m ();
  tdc_measure_ctrl_if #(.COARSE_W(4))  s ();

  tdc_measure_ctrl #(.COARSE_W(16)) u_dut (
    .clk  (clk),
    .iRst (rst),
    .bus  (m.slave)
  );

  tdc_measure_ctrl #(.COARSE_W(4)) u_dut_small (
    .clk  (clk),
    .iRst (rst),
    .bus  (s.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},     32'(m.oBusy),        32'd0);
    check({tag, "_valid"},    32'(m.oValid),       32'd0);
    check({tag, "_start_en"}, 32'(m.oStartEnable), 32'd0);
    check({tag, "_stop_en"},  32'(m.oStopEnable),  32'd0);
    check({tag, "_coarse"},   32'(m.oCoarse),      32'd0);
    check({tag, "_timeout"},  32'(m.oTimeout),     32'd0);
  endtask

  // Start capture at offset 0, tap drops at offset clr, stop capture at offset stp:
  // coarse time is simply stp edges, stop enable is high after edges clr..stp-1.
  task automatic meas(input int pre, input int clr, input int stp, input int rdy_dly);
    m.iArm  = 1'b1;
    m.iTap0 = 1'b0;
    tick();
    m.iArm = 1'b0;
    check("arm_busy",     32'(m.oBusy),        32'd1);
    check("arm_start_en", 32'(m.oStartEnable), 32'd1);
    for (int i = 0; i < pre; i++) begin
      tick();
      check("wait_start_en", 32'(m.oStartEnable), 32'd1);
    end
    for (int j = 0; j <= stp; j++) begin
      m.iTap0 = (j < clr) || (j == stp);
      tick();
      check("start_en_off", 32'(m.oStartEnable), 32'd0);
      check("stop_en",      32'(m.oStopEnable),  32'((j >= clr) && (j < stp)));
      check("valid",        32'(m.oValid),       32'(j == stp));
    end
    m.iTap0 = 1'b0;
    check("coarse",  32'(m.oCoarse),  32'(stp));
    check("timeout", 32'(m.oTimeout), 32'd0);
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      check("hold_valid", 32'(m.oValid), 32'd1);
    end
    m.iReady = 1'b1;
    tick();
    m.iReady = 1'b0;
    check("ack_valid", 32'(m.oValid), 32'd0);
    check("ack_busy",  32'(m.oBusy),  32'd0);
  endtask

  // Saturating case: no usable stop within CMAX periods yields CMAX with the timeout flag.
  task automatic meas_s(input int clr, input int stp);
    int  exp_c;
    bit  exp_t;
    bit  seen;
    exp_t = (stp > CMAX_S) || (clr >= stp);
    exp_c = exp_t ? CMAX_S : stp;
    s.iArm = 1'b1;
    tick();
    s.iArm = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 60 && !seen; j++) begin
      s.iTap0 = (j < clr) || (j == stp);
      tick();
      seen = s.oValid;
    end
    s.iTap0 = 1'b0;
    check("small_valid",   32'(seen),       32'd1);
    check("small_coarse",  32'(s.oCoarse),  32'(exp_c));
    check("small_timeout", 32'(s.oTimeout), 32'(exp_t));
    s.iReady = 1'b1;
    tick();
    s.iReady = 1'b0;
    check("small_idle", 32'(s.oBusy), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    m.iArm = 1'b0; m.iAbort = 1'b0; m.iTap0 = 1'b0; m.iReady = 1'b0;
    s.iArm = 1'b0; s.iAbort = 1'b0; s.iTap0 = 1'b0; s.iReady = 1'b0;
    tick();
    tick();
    check_idle("reset");
    rst = 1'b0;

    // Armed at edge 0, start at edge 10, clear at 12, stop at 15 -> 5.
    meas(9, 2, 5, 2);
    // Hit, drain, hit on consecutive edges -> minimum value 2.
    meas(0, 1, 2, 0);

    for (int k = 0; k < 8; k++) begin
      int clr;
      int stp;
      clr = int'($urandom_range(4, 1));
      stp = clr + int'($urandom_range(20, 1));
      meas(int'($urandom_range(5, 0)), clr, stp, int'($urandom_range(3, 0)));
    end

    // Abort in WAIT_CLEAR with iArm high: back to IDLE, result cleared, re-arm next cycle.
    m.iArm = 1'b1;
    tick();
    m.iArm  = 1'b0;
    m.iTap0 = 1'b1;
    tick();
    tick();
    m.iAbort = 1'b1;
    m.iArm   = 1'b1;
    tick();
    check_idle("abort");
    m.iAbort = 1'b0;
    tick();
    check("rearm_busy",     32'(m.oBusy),        32'd1);
    check("rearm_start_en", 32'(m.oStartEnable), 32'd1);
    m.iArm = 1'b0;
    tick();
    m.iTap0 = 1'b0;
    tick();
    m.iTap0 = 1'b1;
    tick();
    m.iTap0 = 1'b0;
    check("after_abort_valid",  32'(m.oValid),  32'd1);
    check("after_abort_coarse", 32'(m.oCoarse), 32'd2);
    m.iReady = 1'b1;
    tick();
    m.iReady = 1'b0;

    // Backpressure: result held 20 cycles while tap toggles and iArm is asserted.
    m.iArm = 1'b1;
    tick();
    m.iArm  = 1'b0;
    m.iTap0 = 1'b1;
    tick();
    m.iTap0 = 1'b0;
    tick();
    tick();
    m.iTap0 = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      m.iTap0 = 1'($urandom_range(1, 0));
      m.iArm  = 1'b1;
      tick();
      check("bp_valid",    32'(m.oValid),                        32'd1);
      check("bp_coarse",   32'(m.oCoarse),                       32'd3);
      check("bp_timeout",  32'(m.oTimeout),                      32'd0);
      check("bp_enables",  32'(m.oStartEnable | m.oStopEnable), 32'd0);
    end
    m.iTap0  = 1'b0;
    m.iReady = 1'b1;
    tick();
    m.iReady = 1'b0;
    check("bp_ack_valid", 32'(m.oValid), 32'd0);
    check("bp_ack_busy",  32'(m.oBusy),  32'd0);
    tick();
    check("bp_rearm_busy", 32'(m.oBusy), 32'd1);
    m.iArm   = 1'b0;
    m.iAbort = 1'b1;
    tick();
    m.iAbort = 1'b0;
    check_idle("bp_abort");

    // Reset held two cycles in the middle of WAIT_STOP.
    m.iArm = 1'b1;
    tick();
    m.iArm  = 1'b0;
    m.iTap0 = 1'b1;
    tick();
    m.iTap0 = 1'b0;
    tick();
    check("pre_rst_stop_en", 32'(m.oStopEnable), 32'd1);
    rst = 1'b1;
    tick();
    check_idle("rst_mid_1");
    tick();
    check_idle("rst_mid_2");
    rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(m.oBusy), 32'd0);

    meas_s(1, 2);
    meas_s(3, 14);
    meas_s(2, 1000);
    meas_s(100, 1000);
    meas_s(1, 17);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
